// File: rtl/noc_rx_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_rx_sink : NoC ejection endpoint with address check, FIFO, drain pacing |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module noc_rx_sink #(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int D_W        = 256,
    parameter int X          = 0,
    parameter int Y          = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int DRAIN_RATE = 1,
    parameter int N_PACKETS  = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_v,
    input  logic [X_W-1:0] in_x,
    input  logic [Y_W-1:0] in_y,
    input  logic [D_W-1:0] in_data,
    output logic           in_b,
    output logic           out_v,
    output logic [D_W-1:0] out_data,
    input  logic           out_ready,
    output logic [15:0]    rx_count,
    output logic [15:0]    err_count,
    output logic           overflow,
    output logic           done
);

    localparam int               C_AW     = $clog2(FIFO_DEPTH);
    localparam int               C_TW     = (DRAIN_RATE > 1) ? $clog2(DRAIN_RATE) : 1;
    localparam logic [X_W-1:0]   C_X      = X_W'(X);
    localparam logic [Y_W-1:0]   C_Y      = Y_W'(Y);
    localparam logic [C_AW:0]    C_DEPTH  = (C_AW+1)'(FIFO_DEPTH);
    localparam logic [C_AW:0]    C_BTHR   = (C_AW+1)'(FIFO_DEPTH-2);
    localparam logic [C_AW:0]    C_ONE    = (C_AW+1)'(1);
    localparam logic [C_AW-1:0]  C_PINC   = C_AW'(1);
    localparam logic [C_TW-1:0]  C_RELOAD = C_TW'(DRAIN_RATE-1);
    localparam logic [C_TW-1:0]  C_TDEC   = C_TW'(1);
    localparam logic [15:0]      C_NPK    = 16'(N_PACKETS);
    localparam logic [15:0]      C_SAT    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    logic [D_W-1:0]  r_mem [FIFO_DEPTH];
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_AW:0]   r_occ;
    logic [C_TW-1:0] r_timer;
    state_t          r_state;
    logic            r_in_b;
    logic [15:0]     r_rx;
    logic [15:0]     r_err;
    logic            r_ovf;
    logic            r_done;

    logic            w_match;
    logic            w_full;
    logic            w_out_v;
    logic            w_pop;
    logic            w_push;
    logic            w_drop_full;
    logic [C_AW:0]   w_occ_nxt;
    logic [15:0]     w_rx_nxt;
    logic            w_done_nxt;

    always_comb begin
        w_match     = (in_x == C_X) && (in_y == C_Y);
        w_full      = (r_occ == C_DEPTH);
        w_out_v     = (r_occ != '0) && (r_timer == '0);
        w_pop       = w_out_v && out_ready;
        // A pop at the same edge frees the slot, so a full FIFO still accepts.
        w_push      = in_v && w_match && (!w_full || w_pop);
        w_drop_full = in_v && w_match && w_full && !w_pop;
        w_occ_nxt   = r_occ;
        if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + C_ONE;
        end else if (!w_push && w_pop) begin
            w_occ_nxt = r_occ - C_ONE;
        end
        w_rx_nxt    = (w_push && (r_rx != C_SAT)) ? r_rx + 16'd1 : r_rx;
        w_done_nxt  = (w_rx_nxt >= C_NPK) && (w_occ_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_timer  <= '0;
            r_in_b   <= 1'b0;
            r_rx     <= '0;
            r_err    <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PINC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PINC;
                r_timer  <= C_RELOAD;
            end else if (r_timer != '0) begin
                r_timer  <= r_timer - C_TDEC;
            end
            r_occ  <= w_occ_nxt;
            // Two slots of slack cover the switch's one-cycle reaction to in_b.
            r_in_b <= (w_occ_nxt >= C_BTHR);
            r_rx   <= w_rx_nxt;
            if (in_v && !w_match && (r_err != C_SAT)) begin
                r_err <= r_err + 16'd1;
            end
            if (w_drop_full) begin
                r_ovf <= 1'b1;
            end
            if (w_done_nxt) begin
                r_done <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_push) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_occ_nxt == '0) begin
                        r_state <= w_done_nxt ? ST_DRAINED : ST_IDLE;
                    end
                end
                ST_DRAINED: begin
                    r_state <= ST_DRAINED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_b      = r_in_b;
    assign out_v     = w_out_v;
    assign out_data  = r_mem[r_rd_ptr];
    assign rx_count  = r_rx;
    assign err_count = r_err;
    assign overflow  = r_ovf;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/noc_rx_sink.md
NOC_RX_SINK -- requirements
Module: noc_rx_sink

Interface
REQ-001 Parameters SHALL be X_W=2 (x address width), Y_W=2 (y address width), D_W=256 (payload width), X=0 (own column), Y=0 (own row), FIFO_DEPTH=8 (power of two, >=4), DRAIN_RATE=1 (min cycles between pops, >=1), N_PACKETS=128 (flits expected before done).
REQ-002 One clock; reset is synchronous and active-high: clk input 1 (rising-edge clock); rst input 1 (synchronous active-high reset).
REQ-003 in_v input 1 -- ejected flit valid from switch.
REQ-004 in_x input X_W -- flit destination column.
REQ-005 in_y input Y_W -- flit destination row.
REQ-006 in_data input D_W -- flit payload.
REQ-007 in_b output 1 -- backpressure to switch, high = switch must not eject.
REQ-008 out_v output 1 -- drained flit valid.
REQ-009 out_data output D_W -- drained payload.
REQ-010 out_ready input 1 -- downstream accepts out_data.
REQ-011 rx_count output 16 -- accepted flits, saturating.
REQ-012 err_count output 16 -- misrouted flits, saturating.
REQ-013 overflow output 1 -- sticky, flit arrived while FIFO full.
REQ-014 done output 1 -- sticky completion flag.

Function
REQ-015 Flit accepted at a rising edge when in_v=1, (in_x,in_y)==(X,Y) and FIFO not full; payload written to FIFO tail, rx_count+1.
REQ-016 in_v=1 with (in_x,in_y)!=(X,Y): flit discarded, err_count+1, FIFO and rx_count unchanged.
REQ-017 in_v=1, address match, FIFO full: flit discarded, overflow set, rx_count unchanged.
REQ-018 in_b SHALL be a register, next value = (occupancy after this edge >= FIFO_DEPTH-2); gives two slots of slack for the one-cycle switch response.
REQ-019 Occupancy counter 0..FIFO_DEPTH, width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
REQ-020 out_v = (FIFO not empty) && (drain_ok); out_data = FIFO head, stable while out_v=1 and out_ready=0.
REQ-021 Pop at edge where out_v=1 and out_ready=1.
REQ-022 Drain timer: drain_ok=1 when timer==0; pop reloads timer to DRAIN_RATE-1; timer decrements to 0 otherwise; DRAIN_RATE=1 permits a pop every cycle.
REQ-023 Simultaneous push and pop: occupancy unchanged, both succeed even when FIFO full (pop frees the slot in the same edge; the push is accepted, no overflow).
REQ-024 Push into empty FIFO: out_v no earlier than the next cycle (1-cycle fall-through latency, no combinational in->out path).
REQ-025 Counters saturate at 16'hFFFF, never wrap.
REQ-026 done set at edge where rx_count>=N_PACKETS and occupancy==0 after update; remains 1 until reset; further flits still processed.
REQ-027 FSM states IDLE (occupancy 0, done 0), ACTIVE (occupancy>0), DRAINED (done 1); IDLE->ACTIVE on accept; ACTIVE->IDLE on last pop with rx_count<N_PACKETS; ACTIVE->DRAINED on last pop with rx_count>=N_PACKETS; DRAINED exits only on reset.

Reset
REQ-028 rst=1 at an edge: occupancy, pointers, drain timer = 0; in_b=0, out_v=0, rx_count=0, err_count=0, overflow=0, done=0, state IDLE.
REQ-029 rst overrides all simultaneous in_v/out_ready activity; FIFO contents discarded; out_data undefined while out_v=0.
REQ-030 Reset mid-burst: first flit after rst deasserted is accepted normally with rx_count=1.

Verification
REQ-031 X=1,Y=2; in_v 4 cycles to (1,2), data 0xA..0xD, out_ready=1 -> out_data 0xA,0xB,0xC,0xD in order, rx_count=4, err_count=0.
REQ-032 One flit to (0,2) at X=1,Y=2 -> err_count=1, out_v stays 0, rx_count=0.
REQ-033 FIFO_DEPTH=8, out_ready=0, 9 matching flits ignoring in_b -> in_b=1 registered after 6th accept, occupancy 8, overflow=1, rx_count=8.
REQ-034 DRAIN_RATE=3, 3 flits queued, out_ready=1 -> pops exactly 3 cycles apart.
REQ-035 N_PACKETS=2, 2 flits delivered and drained -> done=1 the edge of the 2nd pop; stays 1 after a 3rd flit.
REQ-036 rst pulse with 5 flits queued -> next cycle out_v=0, in_b=0, counters 0.
